// File: rtl/seg_mux_driver.sv
// Multiplexed seven-segment display driver.
// Scans N_DIGITS digits over a shared segment bus with per-digit anode
// selects, a one-cycle blanking gap at every digit switch, 4-bit PWM
// brightness, hex/decimal glyphs, decimal points and leading-zero blanking.
// All outputs are registered and follow the scan state with one cycle of latency.

module seg_mux_driver #(
   parameter int N_DIGITS    = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ena,
   input  logic                    load,
   input  logic [4*N_DIGITS-1:0]   digits_in,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic                    hex_mode,
   input  logic                    blank_lz,
   input  logic [3:0]              brightness,
   output logic [7:0]              seg_data,
   output logic [N_DIGITS-1:0]     an
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   // Internally everything is built active-low; POL=0 flips it at the pins.
   localparam logic                POL     = (ACTIVE_LOW != 0);
   localparam logic [7:0]          SEG_OFF = {8{POL}};
   localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{POL}};

   logic [CNT_W-1:0]      refresh_q, refresh_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [3:0]            pwm_q, pwm_d;
   logic                  gap_q, gap_d;
   logic [4*N_DIGITS-1:0] digits_q, digits_d;
   logic [N_DIGITS-1:0]   dp_q, dp_d;
   logic [7:0]            seg_q, seg_d;
   logic [N_DIGITS-1:0]   an_q, an_d;

   logic                  refresh_wrap;
   logic [3:0]            nib;
   logic                  dp_sel;
   logic                  blank_sel;
   logic                  zero_run;
   logic [6:0]            glyph;
   logic [7:0]            seg_raw;
   logic                  an_on;
   logic [N_DIGITS-1:0]   an_raw;

   // Scan counters, PWM counter and shadow capture.
   always_comb begin
      refresh_wrap = (refresh_q == CNT_W'(REFRESH_DIV - 1));
      refresh_d    = refresh_wrap ? '0 : refresh_q + CNT_W'(1);
      idx_d        = idx_q;
      if (refresh_wrap) begin
         idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      gap_d    = refresh_wrap;
      pwm_d    = pwm_q + 4'd1;
      digits_d = load ? digits_in : digits_q;
      dp_d     = load ? dp_in : dp_q;
   end

   // Glyph selection, blanking and anode decode for the current slot.
   always_comb begin
      nib       = 4'd0;
      dp_sel    = 1'b0;
      blank_sel = 1'b0;
      zero_run  = 1'b1;
      // Walk from the most significant digit down so zero_run tells whether
      // this digit and every digit above it are zero.
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (digits_q[4*i +: 4] == 4'd0);
         if (idx_q == IDX_W'(i)) begin
            nib       = digits_q[4*i +: 4];
            dp_sel    = dp_q[i];
            blank_sel = blank_lz && (i != 0) && zero_run;
         end
      end

      case (nib)
         4'h0:    glyph = 7'h40;
         4'h1:    glyph = 7'h79;
         4'h2:    glyph = 7'h24;
         4'h3:    glyph = 7'h30;
         4'h4:    glyph = 7'h19;
         4'h5:    glyph = 7'h12;
         4'h6:    glyph = 7'h02;
         4'h7:    glyph = 7'h78;
         4'h8:    glyph = 7'h00;
         4'h9:    glyph = 7'h10;
         4'hA:    glyph = hex_mode ? 7'h08 : 7'h7F;
         4'hB:    glyph = hex_mode ? 7'h03 : 7'h7F;
         4'hC:    glyph = hex_mode ? 7'h46 : 7'h7F;
         4'hD:    glyph = hex_mode ? 7'h21 : 7'h7F;
         4'hE:    glyph = hex_mode ? 7'h06 : 7'h7F;
         default: glyph = hex_mode ? 7'h0E : 7'h7F;
      endcase
      if (blank_sel) begin
         glyph = 7'h7F;
      end

      // The decimal point survives blanking on purpose.
      seg_raw = {~dp_sel, glyph};
      seg_d   = POL ? seg_raw : ~seg_raw;

      an_on = !gap_q && ((brightness == 4'd15) || (pwm_q < brightness));
      for (int i = 0; i < N_DIGITS; i++) begin
         an_raw[i] = an_on && (idx_q == IDX_W'(i));
      end
      an_d = POL ? ~an_raw : an_raw;
   end

   // State and output registers; ena low freezes everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         refresh_q <= '0;
         idx_q     <= '0;
         pwm_q     <= 4'd0;
         gap_q     <= 1'b1;
         digits_q  <= '0;
         dp_q      <= '0;
         seg_q     <= SEG_OFF;
         an_q      <= AN_OFF;
      end else if (ena) begin
         refresh_q <= refresh_d;
         idx_q     <= idx_d;
         pwm_q     <= pwm_d;
         gap_q     <= gap_d;
         digits_q  <= digits_d;
         dp_q      <= dp_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   assign seg_data = seg_q;
   assign an       = an_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// Scoreboard bench for seg_mux_driver (N_DIGITS=4, REFRESH_DIV=4, active-low).
// ccnt counts clock edges since reset release; output after edge m reflects
// scan state after edge m-1: digit ((m-1)/4)%4, gap when (m-1)%4==0,
// pwm (m-1)%16.  Expected values below are hand-computed from that.

module tb_seg_mux_driver;

   logic        clk;
   logic        rst;
   logic        ena;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic        hex_mode;
   logic        blank_lz;
   logic [3:0]  brightness;
   logic [7:0]  seg_data;
   logic [3:0]  an;

   int checks   = 0;
   int failures = 0;
   int ccnt;

   typedef struct {
      int         m;
      logic [7:0] seg;
      logic [3:0] an;
      bit         cs;
      string      nm;
   } exp_t;

   exp_t sb[$];

   // Test 1 table: outputs after edges 1..17 with 16'h1234 loaded at edge 1.
   logic [7:0] t1_seg [17] = '{8'hC0, 8'h99, 8'h99, 8'h99, 8'hB0, 8'hB0, 8'hB0, 8'hB0,
                               8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'h99};
   logic [3:0] t1_an  [17] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                               4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
   // brightness=4: anodes for edges 2..20.
   logic [3:0] t4_an  [19] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                               4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hE};

   seg_mux_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .load       (load),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .hex_mode   (hex_mode),
      .blank_lz   (blank_lz),
      .brightness (brightness),
      .seg_data   (seg_data),
      .an         (an)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) ccnt <= 0;
      else     ccnt <= ccnt + 1;
   end

   task automatic check(input string nm, input logic [7:0] s_act, input logic [7:0] s_exp,
                        input logic [3:0] a_act, input logic [3:0] a_exp, input bit cs);
      checks++;
      if ((cs && (s_act !== s_exp)) || (a_act !== a_exp)) begin
         failures++;
         $display("FAIL %s: got seg=%h an=%b, expected seg=%h an=%b (seg checked=%0d)",
                  nm, s_act, a_act, s_exp, a_exp, cs);
      end
   endtask

   task automatic push(input int m, input logic [7:0] s, input logic [3:0] a,
                       input bit cs, input string nm);
      exp_t e;
      e.m = m; e.seg = s; e.an = a; e.cs = cs; e.nm = nm;
      sb.push_back(e);
   endtask

   // Monitor: compare whenever the DUT presents the output the head entry names.
   always @(negedge clk) begin
      if (!rst && sb.size() > 0) begin
         if (sb[0].m == ccnt) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("%s@%0d", e.nm, e.m), seg_data, e.seg, an, e.an, e.cs);
         end else if (sb[0].m < ccnt) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL %s@%0d: entry never compared (now at edge %0d)", e.nm, e.m, ccnt);
         end
      end
   end

   task automatic wait_cnt(input int n);
      int guard = 0;
      while (ccnt < n && guard < 1000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 1000) begin
         checks++;
         failures++;
         $display("FAIL wait_cnt: edge %0d not reached, at %0d", n, ccnt);
      end
   endtask

   task automatic drain();
      int guard = 0;
      while (sb.size() > 0 && guard < 2000) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d entries left unchecked", sb.size());
         sb.delete();
      end
   endtask

   task automatic do_reset(input logic [15:0] d, input logic [3:0] dp);
      rst       = 1'b1;
      ena       = 1'b1;
      load      = 1'b1;
      digits_in = d;
      dp_in     = dp;
      @(negedge clk);
      check("reset_state", seg_data, 8'hFF, an, 4'hF, 1'b1);
      rst = 1'b0;
      wait_cnt(1);
      load = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      ena        = 1'b1;
      load       = 1'b0;
      digits_in  = 16'h0;
      dp_in      = 4'h0;
      hex_mode   = 1'b0;
      blank_lz   = 1'b0;
      brightness = 4'd15;
      #12;

      // Test 1: basic scan of 1234 at full brightness.
      do_reset(16'h1234, 4'h0);
      for (int k = 0; k < 17; k++) push(k + 1, t1_seg[k], t1_an[k], 1'b1, "scan1234");
      drain();

      // Test 2: decimal blanks A/F, then hex_mode live switch.
      do_reset(16'h00AF, 4'h0);
      push(2,  8'hFF, 4'hE, 1'b1, "dec_F");
      push(6,  8'hFF, 4'hD, 1'b1, "dec_A");
      push(10, 8'hC0, 4'hB, 1'b1, "dec_0");
      push(14, 8'hC0, 4'h7, 1'b1, "dec_0hi");
      wait_cnt(14);
      hex_mode = 1'b1;
      push(18, 8'h8E, 4'hE, 1'b1, "hex_F");
      push(22, 8'h88, 4'hD, 1'b1, "hex_A");
      push(26, 8'hC0, 4'hB, 1'b1, "hex_0");
      drain();
      hex_mode = 1'b0;

      // Test 3: leading-zero blanking, then dp on a blanked digit via mid-run load.
      blank_lz = 1'b1;
      do_reset(16'h0005, 4'h0);
      push(2,  8'h92, 4'hE, 1'b1, "lz_d0");
      push(6,  8'hFF, 4'hD, 1'b1, "lz_d1");
      push(10, 8'hFF, 4'hB, 1'b1, "lz_d2");
      push(14, 8'hFF, 4'h7, 1'b1, "lz_d3");
      wait_cnt(14);
      load  = 1'b1;
      dp_in = 4'b0100;
      wait_cnt(15);
      load = 1'b0;
      push(18, 8'h92, 4'hE, 1'b1, "lzdp_d0");
      push(22, 8'hFF, 4'hD, 1'b1, "lzdp_d1");
      push(26, 8'h7F, 4'hB, 1'b1, "lzdp_d2");
      push(30, 8'hFF, 4'h7, 1'b1, "lzdp_d3");
      drain();
      blank_lz = 1'b0;

      // Test 4: brightness 4, then brightness 0 for 64 cycles.
      brightness = 4'd4;
      do_reset(16'h1234, 4'h0);
      for (int k = 0; k < 19; k++) push(k + 2, 8'h00, t4_an[k], 1'b0, "pwm4");
      wait_cnt(20);
      brightness = 4'd0;
      for (int k = 21; k <= 84; k++) push(k, 8'h00, 4'hF, 1'b0, "pwm0");
      drain();
      brightness = 4'd15;

      // Test 5: freeze for 10 cycles with a load pulse that must be ignored.
      do_reset(16'h1234, 4'h0);
      for (int k = 1; k < 6; k++) push(k + 1, t1_seg[k], t1_an[k], 1'b1, "prefreeze");
      wait_cnt(6);
      ena       = 1'b0;
      load      = 1'b1;
      digits_in = 16'h5678;
      dp_in     = 4'hF;
      for (int k = 7; k <= 16; k++) push(k, 8'hB0, 4'hD, 1'b1, "frozen");
      wait_cnt(16);
      ena  = 1'b1;
      load = 1'b0;
      push(17, 8'hB0, 4'hD, 1'b1, "resume");
      push(18, 8'hB0, 4'hD, 1'b1, "resume");
      push(19, 8'hA4, 4'hF, 1'b1, "resume_gap");
      push(20, 8'hA4, 4'hB, 1'b1, "resume_d2");
      push(23, 8'hF9, 4'hF, 1'b1, "resume_gap3");
      push(24, 8'hF9, 4'h7, 1'b1, "resume_d3");
      drain();

      // Test 6: asynchronous reset between edges, then restart from digit 0.
      wait_cnt(30);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", seg_data, 8'hFF, an, 4'hF, 1'b1);
      load      = 1'b0;
      digits_in = 16'h1234;
      dp_in     = 4'h0;
      @(negedge clk);
      rst = 1'b0;
      push(1,  8'hC0, 4'hF, 1'b1, "post_rst");
      push(2,  8'hC0, 4'hE, 1'b1, "post_rst");
      push(6,  8'hC0, 4'hD, 1'b1, "post_rst");
      push(10, 8'hC0, 4'hB, 1'b1, "post_rst");
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule

// File: doc/seg_mux_driver.md
Name: seg_mux_driver

Overview:
- Parametrised successor to the single-digit seven-segment decoder.
- Drives N multiplexed seven-segment digits from one shared segment bus with per-digit anode selects.
- Adds hex/decimal glyph mode, per-digit decimal points, leading-zero blanking, PWM brightness and an anti-ghosting gap at digit switches.
- Sits between the PWM datapath (duty/frequency values already in BCD or hex) and the board display pins.

Parameters:
- N_DIGITS, 4: number of multiplexed digits (2..8).
- REFRESH_DIV, 50000: clock cycles per digit slot (>=4).
- ACTIVE_LOW, 1: 1 = segments and anodes active-low at the pins; 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- ena  in  1  clock enable; low freezes all state and holds outputs.
- load  in  1  capture strobe for digits_in/dp_in, sampled only when ena=1.
- digits_in  in  4*N_DIGITS  nibble i = digit i; digit 0 = least significant, rightmost.
- dp_in  in  N_DIGITS  decimal point request per digit.
- hex_mode  in  1  1 = show 0-F; 0 = show 0-9, with codes 10-15 blank.
- blank_lz  in  1  enable leading-zero blanking.
- brightness  in  4  0 = dark, 15 = full, else duty brightness/16.
- seg_data  out  8  bit7 = dp, bits6..0 = g..a.
- an  out  N_DIGITS  digit selects, one-hot when active.

Behaviour:
Clocking and reset
- Reset is asynchronous and active-high; the single clock is clk.
- During and after rst:
  - shadow digits = 0 and shadow dp = 0.
  - refresh counter = 0, digit index = 0, pwm counter = 0, gap flag = 1.
  - seg_data = all segments off (8'hFF if ACTIVE_LOW, else 8'h00).
  - an = all off.

Load
- ena=1 and load=1 at a clock edge: shadow registers take digits_in/dp_in.
- The new value drives outputs from the next edge onward, including mid-slot.
- load is ignored while ena=0.

Scan
- The refresh counter counts 0..REFRESH_DIV-1 and wraps.
- On wrap, the digit index advances 0,1,..,N_DIGITS-1,0 and the gap flag is set for exactly one cycle.
- While the gap flag is set, an = all off (anti-ghosting) and seg_data is already updated to the new digit.

Brightness
- The 4-bit pwm counter increments every enabled cycle and wraps 15->0.
- Anode for the current digit is active when the gap flag is clear and one of:
  - brightness == 15, or
  - pwm_cnt < brightness.
- brightness == 0 keeps all anodes off permanently.

Glyph encoding (active-low values, bit7..0)
- 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90.
- Hex mode only: A 88, b 83, C C6, d A1, E 86, F 8E.
- Decimal mode, codes 10-15: glyph blank (7F segments off).
- dp_in set: bit7 = 0 (lit).
- ACTIVE_LOW=0: both seg_data and an are bitwise inverted.

Leading-zero blanking
- When blank_lz=1, digit i>0 shows a blank glyph if it and all higher digits are 0.
- Digit 0 is never blanked.
- The dp of a blanked digit is still shown.

Latency and enable
- Outputs are registered: seg_data/an reflect the index, shadow and mode inputs with 1-cycle latency.
- hex_mode, blank_lz and brightness are live (not captured by load).
- ena=0: all counters, shadow registers and outputs hold their values.

Test Plan:
- N_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1, brightness=15. Reset, then load 16'h1234 -> slots cycle an=1110,1101,1011,0111 with seg_data 99,B0,A4,F9; an=1111 for one cycle at each switch.
- hex_mode=0, load 16'h00AF -> digits 0/1 blank (FF); hex_mode=1 -> 8E and 88 shown. blank_lz=1 with value 16'h0005 -> digits 3..1 FF, digit 0 92; with dp_in=4'b0100 -> digit 2 seg_data 7F.
- brightness=4 -> within each slot an active exactly when pwm_cnt in 0..3; brightness=0 -> an stays 1111 for 64 cycles.
- ena=0 mid-slot for 10 cycles, with load pulsed -> seg_data, an and counters unchanged, shadow not updated; on resume, scan continues from the frozen count.
- Assert rst asynchronously mid-slot (between edges) -> seg_data=FF and an=1111 immediately; after release, scan restarts at digit 0 with shadow = 0, showing C0 on digit 0.
